// File: rtl/downstream_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// downstream_req_arbiter_pkg
//
// Shared types for the downstream request arbiter and the cache FSM it feeds.
//   cpu_req_type    : CPU-side request into the cache FSM (addr, data, rw, valid)
//   cpu_result_type : CPU-side result from the cache FSM (data, ready)
//   arb_state_type  : arbiter FSM states ARB -> BUSY -> RESP -> ARB
// -----------------------------------------------------------------------------
package downstream_req_arbiter_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;     // 1 = write, 0 = read
        logic        valid;
    } cpu_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_result_type;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_type;

endpackage

// File: rtl/downstream_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// downstream_req_arbiter_if
//
// Requester-side bundle between the requester fabric and the arbiter.
//   req_valid  [NREQ]       : request pending (driven by requesters)
//   req_rw     [NREQ]       : 1 = write, 0 = read
//   req_addr   [NREQ][32]   : byte address
//   req_data   [NREQ][32]   : write data
//   req_accept [NREQ]       : one-hot accept pulse (driven by arbiter)
//   resp_valid [NREQ]       : one-hot completion pulse (driven by arbiter)
//   resp_data  [32]         : read word, valid with resp_valid, held afterwards
//
// Handshake: a requester raises req_valid[i] with stable rw/addr/data and keeps
// them until req_accept[i] pulses; the arbiter samples the fields in that same
// cycle, so the requester may change or drop them from the next cycle on.
// Dropping req_valid before accept simply withdraws the request. Exactly one
// resp_valid[i] pulse follows every accept unless reset intervenes.
//
// Modports: master = requester fabric, slave = arbiter.
// -----------------------------------------------------------------------------
interface downstream_req_arbiter_if #(
    parameter int NREQ = 4
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_rw;
    logic [NREQ-1:0][31:0]  req_addr;
    logic [NREQ-1:0][31:0]  req_data;
    logic [NREQ-1:0]        req_accept;
    logic [NREQ-1:0]        resp_valid;
    logic [31:0]            resp_data;

    modport master (
        output req_valid, req_rw, req_addr, req_data,
        input  req_accept, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_data,
        output req_accept, resp_valid, resp_data
    );

endinterface

// File: rtl/downstream_req_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
//
// Combinational round-robin picker: returns the first set bit of req strictly
// after last, wrapping modulo NREQ. The requester equal to last is checked
// last, so a requester that just finished ranks behind everyone else.
//   req   [NREQ] : request vector
//   last  [IDW]  : most recently granted index
//   found        : at least one request set
//   idx   [IDW]  : chosen index (0 when nothing is found)
// -----------------------------------------------------------------------------
module rr_priority_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic            found,
    output logic [IDW-1:0]  idx
);

    // One extra bit so last + offset cannot overflow before the wrap.
    localparam int CW = IDW + 1;

    logic [CW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = {1'b0, last} + CW'(i);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!found && req[cand[IDW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/downstream_req_arbiter.sv
// -----------------------------------------------------------------------------
// downstream_req_arbiter
//
// Shares the single CPU-side port of the downstream cache FSM among NREQ
// requesters, one transaction at a time, in round-robin order.
//   clk, rst_n   : clock, asynchronous active-low reset. The cache FSM's
//                  synchronous active-high rst is driven from ~rst_n at the
//                  level above so both sides reset together.
//   req_if       : requester bundle (slave side)
//   cache_req    : request to the cache FSM cpu_req; fields come only from
//                  the hold register, valid only in BUSY
//   cache_res    : result from the cache FSM cpu_res
//   grant_id     : current or most recent owner
//   busy         : transaction in flight (BUSY or RESP)
//   err_timeout  : sticky, set once a transaction has waited TIMEOUT cycles
//   dbg_state    : FSM state for observation
//
// Hit timing: accept (ARB) -> valid (BUSY) -> ready (BUSY) -> resp (RESP).
// RESP always drives valid low for one cycle, so the cache FSM sees an idle
// cycle after every ready and never starts an unowned transaction.
// -----------------------------------------------------------------------------
module downstream_req_arbiter
    import downstream_req_arbiter_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = 255,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    downstream_req_arbiter_if.slave    req_if,
    output cpu_req_type                cache_req,
    input  cpu_result_type             cache_res,
    output logic [IDW-1:0]             grant_id,
    output logic                       busy,
    output logic                       err_timeout,
    output arb_state_type              dbg_state
);

    localparam int CNTW = $clog2(TIMEOUT + 1);

    arb_state_type   state_q, state_d;

    logic            pick_found;
    logic [IDW-1:0]  pick_idx;

    logic [IDW-1:0]  last_grant_q;
    logic [IDW-1:0]  grant_id_q;
    logic [31:0]     hold_addr_q;
    logic [31:0]     hold_data_q;
    logic            hold_rw_q;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_inc;
    logic            err_q;
    logic [31:0]     resp_data_q;

    logic            accept_fire;
    logic            resp_capture;
    logic [NREQ-1:0] accept_vec;

    rr_priority_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (req_if.req_valid),
        .last  (last_grant_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state and strobes
    always_comb begin
        state_d      = state_q;
        accept_vec   = '0;
        accept_fire  = 1'b0;
        resp_capture = 1'b0;
        unique case (state_q)
            ARB: begin
                if (pick_found) begin
                    accept_vec  = NREQ'(1) << pick_idx;
                    accept_fire = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (cache_res.ready) begin
                    resp_capture = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                state_d = ARB;
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    assign cnt_inc = cnt_q + 1'b1;

    // Hold register, grant bookkeeping, wait counter and response data.
    // The counter saturates at TIMEOUT; the transaction keeps waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IDW'(NREQ - 1);
            grant_id_q   <= '0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            hold_rw_q    <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            if (accept_fire) begin
                hold_addr_q  <= req_if.req_addr[pick_idx];
                hold_data_q  <= req_if.req_data[pick_idx];
                hold_rw_q    <= req_if.req_rw[pick_idx];
                last_grant_q <= pick_idx;
                grant_id_q   <= pick_idx;
                cnt_q        <= '0;
            end else if ((state_q == BUSY) && !cache_res.ready &&
                         (cnt_q != CNTW'(TIMEOUT))) begin
                cnt_q <= cnt_inc;
                if (cnt_inc == CNTW'(TIMEOUT)) begin
                    err_q <= 1'b1;
                end
            end
            if (resp_capture) begin
                resp_data_q <= cache_res.data;
            end
        end
    end

    assign cache_req.addr  = hold_addr_q;
    assign cache_req.data  = hold_data_q;
    assign cache_req.rw    = hold_rw_q;
    assign cache_req.valid = (state_q == BUSY);

    assign req_if.req_accept = accept_vec;
    assign req_if.resp_valid = (state_q == RESP) ? (NREQ'(1) << grant_id_q) : '0;
    assign req_if.resp_data  = resp_data_q;

    assign grant_id    = grant_id_q;
    assign busy        = (state_q != ARB);
    assign err_timeout = err_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/downstream_req_arbiter.md
# downstream_req_arbiter

Round-robin arbiter that shares the single CPU-side port of `dm_cache_fsm_downstream` among `NREQ` requesters, e.g. per-venue cancel-order accumulators. It accepts one request at a time and holds the cache request stable for the whole transaction. It returns the read word and a completion pulse to the owning requester, and guarantees an idle gap so the cache FSM never starts a transaction that nobody owns. It sits between the requester fabric and the downstream cache FSM.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..16.
- `TIMEOUT`, 255: BUSY cycles before `err_timeout` sets; counter width is `$clog2(TIMEOUT+1)`.

Ports:
- `clk` input 1: single clock, all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input `[NREQ]`: request pending; held until `req_accept`.
- `req_rw` input `[NREQ]`: 1 = write (accumulate), 0 = read.
- `req_addr` input `[NREQ][32]`: byte address.
- `req_data` input `[NREQ][32]`: write data.
- `req_accept` output `[NREQ]`: one-hot, 1-cycle pulse; fields sampled this cycle.
- `resp_valid` output `[NREQ]`: one-hot, 1-cycle completion pulse.
- `resp_data` output 32: read word, valid with `resp_valid`; held until the next completion.
- `cache_req` output `cpu_req_type`: to the cache FSM `cpu_req`.
- `cache_res` input `cpu_result_type`: from the cache FSM `cpu_res`.
- `grant_id` output `$clog2(NREQ)`: current or most recent owner.
- `busy` output 1: a transaction is in flight (BUSY or RESP).
- `err_timeout` output 1: sticky; cleared only by reset.

## Operation
- The state machine has three states: ARB, BUSY, RESP.
- **ARB**
  - If any `req_valid` is high, pick the first set bit strictly after `last_grant`, wrapping modulo `NREQ`.
  - Pulse `req_accept[pick]`.
  - Latch `addr`, `data` and `rw` into the hold register, set `grant_id` = `last_grant` = pick, clear the timeout counter, go to BUSY.
  - With no request, stay in ARB.
- **BUSY**
  - `cache_req.valid` = 1; `cache_req.addr/data/rw` come from the hold register only and never from live inputs.
  - On `cache_res.ready` = 1, capture `cache_res.data` into `resp_data` (captured for writes too) and go to RESP.
  - Otherwise increment the counter, saturating at `TIMEOUT`. Reaching `TIMEOUT` sets `err_timeout`; the transaction is not aborted and the block keeps waiting.
- **RESP**
  - `cache_req.valid` = 0; pulse `resp_valid[grant_id]`; go to ARB.
- `cache_req.valid` is 0 in ARB and RESP. The cycle after `ready`, the cache FSM is in idle and sees valid = 0.
- Requests arriving while busy wait; `req_accept` never pulses outside ARB.
- Simultaneous requests resolve strictly by round-robin. A requester re-asserting immediately after its own completion ranks last.
- A requester dropping `req_valid` before accept is legal; it is simply not picked.

## Timing
- Reset values:
  - state = ARB; `last_grant` = `NREQ`-1, so requester 0 wins first.
  - `req_accept`, `resp_valid`, `resp_data`, `grant_id` = 0.
  - `cache_req` = all zeros; `busy` = 0; `err_timeout` = 0; counter = 0.
- All outputs are registered or decoded from registered state only, with no combinational path from `req_*` to `cache_req`. The exception is `req_accept`, which is decoded from state plus the pick.
- Cache hit latency: accept in cycle 0, BUSY with valid in cycle 1, cache `ready` in cycle 2, `resp_valid` in cycle 3. A hit therefore takes 4 cycles per transaction. Back-to-back throughput is one transaction per 4 cycles for hits.
- Miss latency is the hit latency plus the cache's allocate and write-back cycles; the counter runs throughout.
- Reset asserted mid-operation:
  - Immediate return to ARB with valid = 0, and any pending response is dropped.
  - The cache FSM has a synchronous active-high `rst`; the top level drives it from `~rst_n` so both reset together.

## Structure
- Add to `cache_def`: `arb_state_type` enum {ARB, BUSY, RESP}.
- Reuse `cpu_req_type` and `cpu_result_type` unchanged.
- Sub-module `rr_priority_pick`: combinational, `NREQ`-bit request vector plus `last_grant` in; `found` and index out.
- The top-level arbiter instantiates one `rr_priority_pick` and holds the FSM, hold register and counter.

## Test plan
- Reset release, `req_valid[2]` = 1, read at addr 0x40 (hit, line data 0x0000_0015) → `req_accept[2]` in cycle 0, `resp_valid[2]` in cycle 3, `resp_data` = 0x15, `cache_req.valid` high only in cycles 1–2.
- All four requesters hold `req_valid` for 20 transactions → grants in order 0,1,2,3,0,…, with no requester granted twice in a row while others wait.
- Requester 1 writes 0x10 to addr 0x80 (miss, clean line) → `cache_req` stays stable through allocate and compare_tag, `resp_valid[1]` fires once, and a subsequent read returns the accumulated value.
- Cache `ready` stuck low for 300 cycles with `TIMEOUT` = 255 → `err_timeout` rises after BUSY cycle 255 and stays high; no `resp_valid`; `ready` in cycle 300 completes normally.
- `rst_n` pulled low in BUSY → `cache_req.valid` drops asynchronously, no `resp_valid`, first post-reset grant goes to requester 0.
- `req_valid[3]` pulses 1 cycle while BUSY and drops → never accepted, no spurious response.
